// File: rtl/prime_disp_pkg.sv
// Shared types and constants for the prime BCD display: FSM states, segment codes
// and the digit-to-segment decode (active-low, index 0 = segment a).
package prime_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_CAPTURE,
    ST_CONVERT,
    ST_UPDATE
  } state_t;

  localparam logic [0:6]  SEG_BLANK = 7'b1111111;
  localparam logic [0:6]  SEG_DASH  = 7'b1111110;
  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [15:0] BIN_MAX   = 16'd9999;

  function automatic logic [0:6] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 4 BCD digits, one shift per cycle.
// done is high on the final step cycle; bcd/ovf are stable once busy drops.
module bin2bcd_seq
  import prime_disp_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  logic [15:0] sh, acc, adj;
  logic [3:0]  step;
  logic        ovf_q;

  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // The thousands nibble may overflow for inputs > 9999; ovf_q masks that case.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sh    <= '0;
      acc   <= '0;
      step  <= '0;
      busy  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (start) begin
      sh    <= bin;
      acc   <= '0;
      step  <= '0;
      busy  <= 1'b1;
      ovf_q <= (bin > BIN_MAX);
    end else if (busy) begin
      acc  <= {adj[14:0], sh[15]};
      sh   <= {sh[14:0], 1'b0};
      step <= step + 4'd1;
      if (step == 4'd15) busy <= 1'b0;
    end
  end

  assign done = busy && (step == 4'd15);
  assign bcd  = ovf_q ? BCD_MAX : acc;
  assign ovf  = ovf_q;

endmodule

// File: rtl/prime_bcd_display.sv
// Paces Print requests to the prime generator, converts each returned prime to BCD
// and scans it onto a multiplexed active-low 7-segment display.
module prime_bcd_display
  import prime_disp_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int INTERVAL_CYCLES = 20_000_000,
  parameter int REFRESH_CYCLES  = 100_000,
  parameter int NUM_AN          = 4,
  parameter int SEGDIS          = 7
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Enable,
  input  logic [DATA_WIDTH-1:0] Prime,
  output logic                  Print,
  output logic [15:0]           Bcd,
  output logic                  Ovf,
  output logic [0:SEGDIS-1]     seg,
  output logic [NUM_AN-1:0]     an
);

  localparam int ICW = $clog2(INTERVAL_CYCLES);
  localparam int RCW = $clog2(REFRESH_CYCLES);
  localparam int DW  = $clog2(NUM_AN);
  localparam logic [ICW-1:0] ICNT_LAST = ICW'(INTERVAL_CYCLES - 1);
  localparam logic [RCW-1:0] RCNT_LAST = RCW'(REFRESH_CYCLES - 1);
  localparam logic [DW-1:0]  DIG_LAST  = DW'(NUM_AN - 1);

  state_t         state, state_nxt;
  logic [ICW-1:0] icnt;
  logic [RCW-1:0] rcnt;
  logic [DW-1:0]  dig;
  logic           conv_start, conv_busy, conv_done, conv_ovf, shown;
  logic [15:0]    conv_bcd, upper;

  bin2bcd_seq u_b2b (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (conv_start),
    .bin   (Prime[15:0]),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    Print      = 1'b0;
    conv_start = 1'b0;
    case (state)
      ST_IDLE:    if (Enable) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!Enable)                              state_nxt = ST_IDLE;
        else if (icnt == ICNT_LAST && !conv_busy) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        Print     = 1'b1;
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        conv_start = 1'b1;
        state_nxt  = ST_CONVERT;
      end
      ST_CONVERT: if (conv_done) state_nxt = ST_UPDATE;
      ST_UPDATE:  state_nxt = Enable ? ST_WAIT : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Counter restarts on REQ entry so the Print period is exactly INTERVAL_CYCLES.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                          icnt <= '0;
    else if (state_nxt == ST_IDLE || state_nxt == ST_REQ) icnt <= '0;
    else                                              icnt <= icnt + 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Bcd   <= '0;
      Ovf   <= 1'b0;
      shown <= 1'b0;
    end else if (state == ST_UPDATE) begin
      Bcd   <= conv_bcd;
      Ovf   <= conv_ovf;
      shown <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rcnt <= '0;
      dig  <= '0;
    end else if (rcnt == RCNT_LAST) begin
      rcnt <= '0;
      dig  <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    upper = Bcd >> (4 * dig);
    if (!shown)                           seg = SEG_BLANK;
    else if (Ovf)                         seg = SEG_DASH;
    else if (dig != '0 && upper == 16'd0) seg = SEG_BLANK;
    else                                  seg = seg_decode(Bcd[4*dig +: 4]);
    an = shown ? ~(NUM_AN'(1) << dig) : '1;
  end

endmodule

// File: tb/tb_prime_bcd_display.sv
// Randomized bench for prime_bcd_display: an event-schedule model predicts Print
// timing, the displayed value and the scanned segment/anode pattern every cycle.
module tb_prime_bcd_display;

  localparam int INTV = 100;
  localparam int REFR = 4;

  logic        Clk = 1'b0, Rst = 1'b1, Enable = 1'b0;
  logic [15:0] Prime = '0;
  logic        Print, Ovf;
  logic [15:0] Bcd;
  logic [0:6]  seg;
  logic [3:0]  an;

  prime_bcd_display #(
    .DATA_WIDTH(16), .INTERVAL_CYCLES(INTV), .REFRESH_CYCLES(REFR), .NUM_AN(4), .SEGDIS(7)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Prime(Prime),
    .Print(Print), .Bcd(Bcd), .Ovf(Ovf), .seg(seg), .an(an)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  // model state
  bit active = 0, has_t = 0, pend_v = 0, shown = 0, exp_print = 0;
  int next_print = 0, last_t = 0, pend_at = 0, pend_val = 0, cur_val = 0, hold = 0;
  int dq[$] = '{7919, 2, 10007, 9999, 10000, 0, 5, 1000, 65535, 10};
  logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int pw [4] = '{1, 10, 100, 1000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (dq.size() > 0) return dq.pop_front();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int d);
    if (v > 9999) return 7'b1111110;
    if (d > 0 && v < pw[d]) return 7'b1111111;
    return segtab[(v / pw[d]) % 10];
  endfunction

  task automatic step();
    int d;
    @(negedge Clk);
    if (Rst) begin
      chk("rst_print", Print, 0);
      chk("rst_bcd", Bcd, 0);
      chk("rst_ovf", Ovf, 0);
      chk("rst_an", an, 4'hf);
      chk("rst_seg", seg, 7'h7f);
    end else begin
      cyc++;
      if (pend_v && cyc == pend_at) begin
        cur_val = pend_val;
        shown   = 1;
        pend_v  = 0;
      end
      if (!active) begin
        if (Enable) begin
          active     = 1;
          next_print = cyc + INTV - 1;
        end
      end else if (!Enable && !(has_t && cyc - 1 >= last_t && cyc - 1 <= last_t + 17)) begin
        active = 0;
      end
      exp_print = 0;
      if (active && cyc == next_print) begin
        exp_print  = 1;
        last_t     = cyc;
        has_t      = 1;
        next_print = cyc + INTV;
        pend_val   = pick();
        pend_at    = cyc + 19;
        pend_v     = 1;
        hold       = 2;
      end
      chk("print", Print, exp_print);
      chk("bcd", Bcd, shown ? bcd_of(cur_val) : 16'h0);
      chk("ovf", Ovf, shown && cur_val > 9999);
      if (!shown) begin
        chk("an_blank", an, 4'hf);
        chk("seg_blank", seg, 7'h7f);
      end else begin
        d = (cyc / REFR) % 4;
        chk("an", an, 4'hf & ~(4'b0001 << d));
        chk("seg", seg, seg_of(cur_val, d));
      end
    end
    if (hold > 0) begin
      Prime = 16'(pend_val);
      hold--;
    end else begin
      Prime = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic apply_reset(input int n);
    Rst = 1'b1;
    repeat (n) step();
    cyc = 0; active = 0; has_t = 0; pend_v = 0; shown = 0; cur_val = 0; hold = 0;
    Rst = 1'b0;
  endtask

  task automatic wait_print(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (Print === 1'b1) begin
        t = cyc;
        return;
      end
    end
    chk("print_timeout", 0, 1);
  endtask

  initial begin
    int t1, t2, t, e;
    Enable = 1'b1;
    apply_reset(3);
    wait_print(t1);
    chk("first_print", t1, INTV);
    wait_print(t2);
    chk("period", t2 - t1, INTV);
    wait_print(t);
    chk("period2", t - t2, INTV);
    // abort a conversion with reset during CONVERT
    wait_print(t);
    repeat (8) step();
    apply_reset(2);
    wait_print(t);
    chk("restart", t, INTV);
    repeat (25) step();
    // drop Enable mid-conversion: value still lands, then no more requests
    wait_print(t);
    repeat (5) step();
    Enable = 1'b0;
    repeat (150) step();
    // short enable burst dropped while waiting
    Enable = 1'b1;
    repeat (40) step();
    Enable = 1'b0;
    repeat (120) step();
    e = cyc;
    Enable = 1'b1;
    wait_print(t);
    chk("reenable", t - e, INTV);
    repeat (8) wait_print(t);
    repeat (25) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
